// File: rtl/msk_aes_job_sequencer_pkg.sv
// Shared types and constants for the masked AES job sequencer.
// FSM encoding, share bus width and FIFO pointer sizing.
package msk_aes_job_sequencer_pkg;

  localparam int NSHARES = 2;
  localparam int BLK_W   = 128;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_KS    = 3'd1;
  localparam logic [2:0] S_KSW   = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  typedef struct packed {
    logic inverse;
    logic m256;
    logic m192;
  } job_mode_t;

  // Key-size code; 256 takes priority over 192.
  function automatic logic [1:0] mode_code(
    input job_mode_t m
  );
    if (m.m256)      return 2'b10;
    else if (m.m192) return 2'b01;
    else             return 2'b00;
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int bus_w(input int d);
    return BLK_W * d;
  endfunction

endpackage

// File: rtl/msk_aes_job_sequencer_if.sv
// Host-side job, plaintext and ciphertext handshakes.
// master = bus adapter side, slave = sequencer.
interface msk_aes_job_sequencer_if #(
  parameter int D    = 2,
  parameter int NB_W = 8
);
  import msk_aes_job_sequencer_pkg::*;

  logic              job_valid;
  logic              job_ready;
  logic [NB_W-1:0]   job_nblocks_m1;
  logic              job_inverse;
  logic              job_mode_256;
  logic              job_mode_192;
  logic              job_new_key;
  logic              job_abort;
  logic              job_done;

  logic              blk_valid;
  logic              blk_ready;
  logic [BLK_W*D-1:0] sh_blk;

  logic              out_valid;
  logic              out_ready;
  logic [BLK_W*D-1:0] sh_out;
  logic              out_last;

  modport master (
    output job_valid, job_nblocks_m1,
    output job_inverse, job_mode_256,
    output job_mode_192, job_new_key,
    output job_abort,
    output blk_valid, sh_blk, out_ready,
    input  job_ready, job_done,
    input  blk_ready,
    input  out_valid, sh_out, out_last
  );

  modport slave (
    input  job_valid, job_nblocks_m1,
    input  job_inverse, job_mode_256,
    input  job_mode_192, job_new_key,
    input  job_abort,
    input  blk_valid, sh_blk, out_ready,
    output job_ready, job_done,
    output blk_ready,
    output out_valid, sh_out, out_last
  );

endinterface

// File: rtl/msk_aes_job_sequencer_share.sv
// Share FIFO: first-word-fall-through, last tag per entry.
// Read port drives the all-zero sharing while empty.
module msk_share_fifo
  import msk_aes_job_sequencer_pkg::*;
#(
  parameter int D     = 2,
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_flush,
  input  logic               i_push,
  input  logic [WIDTH*D-1:0] i_data,
  input  logic               i_tag,
  input  logic               i_pop,
  output logic               o_full,
  output logic               o_empty,
  output logic [WIDTH*D-1:0] o_data,
  output logic               o_tag
);

  localparam int PW = ptr_w(DEPTH);
  localparam logic [PW:0] C_FULL = (PW+1)'(DEPTH);

  logic [WIDTH*D-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]   r_tag;
  logic [PW-1:0]      r_wr;
  logic [PW-1:0]      r_rd;
  logic [PW:0]        r_cnt;
  logic               w_wr;
  logic               w_rd;

  assign o_full  = (r_cnt == C_FULL);
  assign o_empty = (r_cnt == '0);
  assign w_rd    = i_pop & ~o_empty;
  assign w_wr    = i_push & (~o_full | w_rd);

  // Select is pure control: shares pass through untouched.
  assign o_data = o_empty ? '0 : r_mem[r_rd];
  assign o_tag  = ~o_empty & r_tag[r_rd];

  // Share storage, written only on an accepted push.
  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem[r_wr] <= i_data;
      r_tag[r_wr] <= i_tag;
    end
  end

  // Pointers wrap naturally; DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_rst | i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wr <= r_wr + 1'b1;
      if (w_rd) r_rd <= r_rd + 1'b1;
      unique case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/msk_aes_job_sequencer.sv
// Multi-block job front-end for the masked AES core.
// Issues blocks, inserts key-schedule passes, buffers results.
module msk_aes_job_sequencer
  import msk_aes_job_sequencer_pkg::*;
#(
  parameter int d     = 2,
  parameter int NB_W  = 8,
  parameter int DEPTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  msk_aes_job_sequencer_if.slave bus,
  input  logic                 i_rnd_ok,
  output logic                 o_core_rst,
  output logic                 o_core_valid_in,
  input  logic                 i_core_in_ready,
  input  logic                 i_core_cipher_valid,
  output logic                 o_core_out_ready,
  input  logic                 i_core_busy,
  output logic                 o_core_inverse,
  output logic                 o_core_key_schedule_only,
  output logic                 o_core_mode_256,
  output logic                 o_core_mode_192,
  output logic [BLK_W*d-1:0]   o_core_sh_plaintext,
  input  logic [BLK_W*d-1:0]   i_core_sh_ciphertext
);

  logic [2:0]      r_state;
  logic [NB_W-1:0] r_nb_m1;
  logic [NB_W-1:0] r_issue_cnt;
  logic [NB_W-1:0] r_push_cnt;
  job_mode_t       r_mode;
  logic            r_ks_done;
  logic [1:0]      r_ks_mode;
  logic            r_abort_done;

  job_mode_t w_new_mode;
  logic      w_idle;
  logic      w_abort;
  logic      w_flush;
  logic      w_accept;
  logic      w_need_ks;
  logic      w_go;
  logic      w_ks_fire;
  logic      w_issue;
  logic      w_active;
  logic      w_full;
  logic      w_empty;
  logic      w_push;
  logic      w_pop;
  logic      w_last_tag;
  logic      w_finish;

  assign w_new_mode = {bus.job_inverse,
                       bus.job_mode_256,
                       bus.job_mode_192};

  assign w_idle   = (r_state == S_IDLE);
  assign w_abort  = bus.job_abort;
  assign w_flush  = w_abort & ~w_idle;
  assign w_accept = bus.job_valid & w_idle & ~w_abort;

  assign w_need_ks = bus.job_inverse
                   & (bus.job_new_key | ~r_ks_done
                      | (mode_code(w_new_mode) != r_ks_mode));

  assign w_go      = i_core_in_ready & i_rnd_ok & ~w_abort;
  assign w_ks_fire = (r_state == S_KS) & w_go;
  assign w_issue   = (r_state == S_ISSUE) & bus.blk_valid & w_go;
  assign w_active  = (r_state == S_ISSUE) | (r_state == S_DRAIN);

  assign w_push     = w_active & i_core_cipher_valid
                    & ~w_full & ~w_abort;
  assign w_pop      = bus.out_valid & bus.out_ready;
  assign w_last_tag = (r_push_cnt == r_nb_m1);
  assign w_finish   = (r_state == S_DRAIN) & w_push & w_last_tag;

  assign bus.job_ready = w_idle;
  assign bus.blk_ready = w_issue;
  assign bus.job_done  = r_abort_done | w_finish;
  assign bus.out_valid = ~w_empty;

  assign o_core_rst               = i_rst | w_abort;
  assign o_core_valid_in          = w_ks_fire | w_issue;
  assign o_core_key_schedule_only = (r_state == S_KS);
  assign o_core_out_ready         = ~w_full;
  assign o_core_inverse           = r_mode.inverse;
  assign o_core_mode_256          = r_mode.m256;
  assign o_core_mode_192          = r_mode.m192;
  assign o_core_sh_plaintext      = bus.sh_blk;

  msk_share_fifo #(
    .D     (d),
    .WIDTH (BLK_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_data  (i_core_sh_ciphertext),
    .i_tag   (w_last_tag),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_data  (bus.sh_out),
    .o_tag   (bus.out_last)
  );

  // Job FSM, block counters and key-schedule cache.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_nb_m1      <= '0;
      r_issue_cnt  <= '0;
      r_push_cnt   <= '0;
      r_mode       <= '0;
      r_ks_done    <= 1'b0;
      r_ks_mode    <= 2'b00;
      r_abort_done <= 1'b0;
    end else begin
      r_abort_done <= w_flush;
      if (w_flush) begin
        r_state   <= S_IDLE;
        r_ks_done <= 1'b0;
      end else if (!w_abort) begin
        if (w_push) r_push_cnt <= r_push_cnt + 1'b1;
        unique case (1'b1)
          (r_state == S_IDLE): begin
            if (w_accept) begin
              r_mode      <= w_new_mode;
              r_nb_m1     <= bus.job_nblocks_m1;
              r_issue_cnt <= bus.job_nblocks_m1;
              r_push_cnt  <= '0;
              r_state     <= w_need_ks ? S_KS : S_ISSUE;
              if (!bus.job_inverse && bus.job_new_key)
                r_ks_done <= 1'b0;
            end
          end
          (r_state == S_KS): begin
            if (w_ks_fire) r_state <= S_KSW;
          end
          (r_state == S_KSW): begin
            if (!i_core_busy) begin
              r_state   <= S_ISSUE;
              r_ks_done <= 1'b1;
              r_ks_mode <= mode_code(r_mode);
            end
          end
          (r_state == S_ISSUE): begin
            if (w_issue) begin
              if (r_issue_cnt == '0) r_state <= S_DRAIN;
              else r_issue_cnt <= r_issue_cnt - 1'b1;
            end
          end
          (r_state == S_DRAIN): begin
            if (w_finish) r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
